tcam_rule_mgr: RTL and testbench
================================

# tcam_rule_mgr

Rule-table manager that owns the write port of a TCAM instance. It accepts insert/delete/clear requests over a valid/ready handshake and allocates the lowest free entry for inserts. It tracks occupancy in a bitmap and drives the TCAM's per-entry write interface (we/idx/data/mask/vld), returning the result on a response handshake. It sits between the control plane (host register interface) and the TCAM array.

## Interface
- `TCAM_WIDTH`, 32, key/mask width in bits
- `TCAM_DEPTH`, 16, number of TCAM entries (power of two, ≥2)
- Derived: `IDX_W = $clog2(TCAM_DEPTH)`, `CNT_W = $clog2(TCAM_DEPTH+1)`

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_vld` in 1: request valid
- `req_rdy` out 1: request ready
- `req_op` in 2: `tcam_op_t`, 0=INSERT, 1=DELETE, 2=CLEAR, 3=reserved
- `req_idx` in IDX_W: target entry for DELETE, ignored otherwise
- `req_data` in TCAM_WIDTH: key for INSERT
- `req_mask` in TCAM_WIDTH: compare mask for INSERT, 1 = bit compared
- `rsp_vld` out 1: response valid
- `rsp_rdy` in 1: response ready
- `rsp_ok` out 1: operation succeeded
- `rsp_idx` out IDX_W: entry written (INSERT/DELETE), 0 for CLEAR/failure
- `tcam_we` out 1: TCAM write enable
- `tcam_idx` out IDX_W: TCAM write index
- `tcam_data` out TCAM_WIDTH: TCAM write key
- `tcam_mask` out TCAM_WIDTH: TCAM write mask
- `tcam_vld` out 1: TCAM entry valid bit written
- `occ_cnt` out CNT_W: number of occupied entries
- `full` out 1: `occ_cnt == TCAM_DEPTH`
- `empty` out 1: `occ_cnt == 0`

## Operation
- FSM states: IDLE, WRITE, CLEAR, RESP.
- IDLE: `req_rdy=1`. On `req_vld && req_rdy`, the request is latched and the next state is chosen:
  - INSERT, not full: the allocator gives the lowest index with bitmap bit 0. Go to WRITE with data=req_data, mask=req_mask, vld=1.
  - INSERT, full: go to RESP with ok=0, idx=0, and no write.
  - DELETE with bitmap[req_idx]=1: go to WRITE with data=0, mask=0, vld=0.
  - DELETE with bitmap[req_idx]=0: go to RESP with ok=0, idx=0.
  - CLEAR: go to CLEAR with counter=0.
  - Reserved op: go to RESP with ok=0.
- WRITE: `tcam_we=1` for exactly one cycle. The bitmap bit is set (INSERT) or cleared (DELETE) on the same edge. Go to RESP with ok=1 and idx=the entry written.
- CLEAR: one write per cycle, with `tcam_idx`=counter and data/mask/vld=0. After idx `TCAM_DEPTH-1` is written, the bitmap is zeroed and the FSM goes to RESP with ok=1, idx=0. The counter is IDX_W wide; the wrap at the last entry ends the sweep.
- RESP: `rsp_vld=1`, and `rsp_ok`/`rsp_idx` are held stable until `rsp_rdy`. On handshake, go to IDLE.
- `req_rdy=0` in every state except IDLE. There is no request pipelining.
- Duplicate keys are not detected. Two INSERTs with identical key/mask occupy two entries.
- `occ_cnt` is the registered popcount of the bitmap. `full` and `empty` are derived from it.

## Timing
- Reset values: `req_rdy=1` (IDLE). All other outputs are 0: `rsp_vld`, `rsp_ok`, `rsp_idx`, `tcam_*`, `occ_cnt`. `full=0`, `empty=1`. The bitmap is all-zero.
- All `tcam_*` and `rsp_*` outputs are registered.
- Successful INSERT/DELETE: accepted at edge N, `tcam_we` high in cycle N+1, `rsp_vld` from cycle N+2.
- Failed op: accepted at edge N, `rsp_vld` from cycle N+1. `tcam_we` is never asserted.
- CLEAR: `tcam_we` is high in cycles N+1 … N+TCAM_DEPTH, and `rsp_vld` is asserted from cycle N+TCAM_DEPTH+1.
- `occ_cnt`, `full` and `empty` reflect a write one cycle after the `tcam_we` cycle, i.e. in the first RESP cycle.
- Any `rsp_rdy` stall extends RESP. `req_rdy` stays 0 throughout the stall.
- Reset mid-operation aborts immediately:
  - the bitmap is cleared and any pending response is dropped;
  - the TCAM must share the same reset so that array contents agree with the bitmap.

## Structure
- `cam_defs.svh` gains:
  - the `tcam_op_t` enum (`TCAM_OP_INSERT`, `TCAM_OP_DELETE`, `TCAM_OP_CLEAR`);
  - the FSM state enum `tcam_mgr_state_t`.
- One sub-module, `tcam_alloc`:
  - combinational lowest-zero finder over the DEPTH-bit bitmap;
  - outputs `free_idx` (IDX_W) and `free_vld`.
- Top-level: FSM, request latch, bitmap, clear counter, popcount.

## Test plan
- Reset, then INSERT key 0xDEAD_BEEF, mask 0xFFFF_0000:
  - `tcam_we` in cycle N+1 with idx=0, data 0xDEAD_BEEF, mask 0xFFFF_0000, vld=1;
  - rsp ok=1, idx=0; `occ_cnt`=1, `empty`=0.
- 16 INSERTs: rsp_idx = 0..15 in order and `full`=1. A 17th INSERT gives ok=0, no `tcam_we`, response in N+1.
- After filling, DELETE idx 5:
  - `tcam_we` with idx=5, vld=0, data=0, mask=0;
  - the next INSERT gets idx=5.
- DELETE idx 9 on an empty table gives ok=0 and no write. Reserved op 3 gives ok=0.
- CLEAR on a full table:
  - 16 consecutive `tcam_we` cycles with idx 0..15, vld=0;
  - rsp ok=1 at N+17, `occ_cnt`=0.
- Hold `rsp_rdy`=0 for 5 cycles: `rsp_vld`/`rsp_ok`/`rsp_idx` stable, `req_rdy`=0. Assert `rst_n`=0 during a CLEAR sweep: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/tcam_rule_mgr_pkg.sv
// Shared types for the TCAM rule-table manager: request opcodes and FSM states.
// Pure type definitions, no logic.
package tcam_rule_mgr_pkg;

  typedef enum logic [1:0] {
    TCAM_OP_INSERT = 2'd0,
    TCAM_OP_DELETE = 2'd1,
    TCAM_OP_CLEAR  = 2'd2,
    TCAM_OP_RSVD   = 2'd3
  } tcam_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_RESP  = 2'd3
  } tcam_mgr_state_t;

endpackage

// File: rtl/tcam_alloc.sv
// Lowest-free-entry finder over the occupancy bitmap.
// Purely combinational; no handshake, no backpressure.
module tcam_alloc #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] bitmap,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_vld
);

  // Scan from the top so the last hit, the lowest zero bit, wins.
  always_comb begin
    free_idx = '0;
    free_vld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        free_idx = IDX_W'(i);
        free_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcam_rule_mgr.sv
// TCAM write-port owner: insert/delete/clear with lowest-free allocation and occupancy tracking.
// Insert/delete write at N+1, respond at N+2; failures respond at N+1; req_rdy low until rsp handshake.
module tcam_rule_mgr
  import tcam_rule_mgr_pkg::*;
#(
  parameter  int TCAM_WIDTH = 32,
  parameter  int TCAM_DEPTH = 16,
  localparam int IDX_W      = $clog2(TCAM_DEPTH),
  localparam int CNT_W      = $clog2(TCAM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  tcam_op_t              req_op,
  input  logic [IDX_W-1:0]      req_idx,
  input  logic [TCAM_WIDTH-1:0] req_data,
  input  logic [TCAM_WIDTH-1:0] req_mask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic                  rsp_ok,
  output logic [IDX_W-1:0]      rsp_idx,
  output logic                  tcam_we,
  output logic [IDX_W-1:0]      tcam_idx,
  output logic [TCAM_WIDTH-1:0] tcam_data,
  output logic [TCAM_WIDTH-1:0] tcam_mask,
  output logic                  tcam_vld,
  output logic [CNT_W-1:0]      occ_cnt,
  output logic                  full,
  output logic                  empty
);

  tcam_mgr_state_t       r_state;
  logic [TCAM_DEPTH-1:0] r_bitmap;
  logic [TCAM_DEPTH-1:0] w_bitmap_nxt;
  logic [IDX_W-1:0]      r_cnt;
  logic                  r_ins;
  logic [CNT_W-1:0]      r_occ;
  logic [CNT_W-1:0]      w_pop;
  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_free_vld;

  logic                  r_req_rdy;
  logic                  r_rsp_vld;
  logic                  r_rsp_ok;
  logic [IDX_W-1:0]      r_rsp_idx;
  logic                  r_tcam_we;
  logic [IDX_W-1:0]      r_tcam_idx;
  logic [TCAM_WIDTH-1:0] r_tcam_data;
  logic [TCAM_WIDTH-1:0] r_tcam_mask;
  logic                  r_tcam_vld;

  tcam_alloc #(
    .DEPTH (TCAM_DEPTH),
    .IDX_W (IDX_W)
  ) u_alloc (
    .bitmap   (r_bitmap),
    .free_idx (w_free_idx),
    .free_vld (w_free_vld)
  );

  // Bitmap moves on the same edge that ends the TCAM write, so occupancy is current in RESP.
  always_comb begin
    w_bitmap_nxt = r_bitmap;
    if (r_state == ST_WRITE) begin
      w_bitmap_nxt[r_tcam_idx] = r_ins;
    end else if (r_state == ST_CLEAR && (&r_cnt)) begin
      w_bitmap_nxt = '0;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < TCAM_DEPTH; i++) begin
      w_pop = w_pop + CNT_W'(w_bitmap_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bitmap    <= '0;
      r_occ       <= '0;
      r_cnt       <= '0;
      r_ins       <= 1'b0;
      r_req_rdy   <= 1'b1;
      r_rsp_vld   <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_rsp_idx   <= '0;
      r_tcam_we   <= 1'b0;
      r_tcam_idx  <= '0;
      r_tcam_data <= '0;
      r_tcam_mask <= '0;
      r_tcam_vld  <= 1'b0;
    end else begin
      r_bitmap <= w_bitmap_nxt;
      r_occ    <= w_pop;
      case (r_state)
        ST_IDLE: begin
          if (req_vld) begin
            r_req_rdy <= 1'b0;
            case (req_op)
              TCAM_OP_INSERT: begin
                if (w_free_vld) begin
                  r_ins       <= 1'b1;
                  r_tcam_we   <= 1'b1;
                  r_tcam_idx  <= w_free_idx;
                  r_tcam_data <= req_data;
                  r_tcam_mask <= req_mask;
                  r_tcam_vld  <= 1'b1;
                  r_state     <= ST_WRITE;
                end else begin
                  r_rsp_vld <= 1'b1;
                  r_rsp_ok  <= 1'b0;
                  r_rsp_idx <= '0;
                  r_state   <= ST_RESP;
                end
              end
              TCAM_OP_DELETE: begin
                if (r_bitmap[req_idx]) begin
                  r_ins       <= 1'b0;
                  r_tcam_we   <= 1'b1;
                  r_tcam_idx  <= req_idx;
                  r_tcam_data <= '0;
                  r_tcam_mask <= '0;
                  r_tcam_vld  <= 1'b0;
                  r_state     <= ST_WRITE;
                end else begin
                  r_rsp_vld <= 1'b1;
                  r_rsp_ok  <= 1'b0;
                  r_rsp_idx <= '0;
                  r_state   <= ST_RESP;
                end
              end
              TCAM_OP_CLEAR: begin
                r_cnt       <= '0;
                r_tcam_we   <= 1'b1;
                r_tcam_idx  <= '0;
                r_tcam_data <= '0;
                r_tcam_mask <= '0;
                r_tcam_vld  <= 1'b0;
                r_state     <= ST_CLEAR;
              end
              default: begin
                r_rsp_vld <= 1'b1;
                r_rsp_ok  <= 1'b0;
                r_rsp_idx <= '0;
                r_state   <= ST_RESP;
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_tcam_we <= 1'b0;
          r_rsp_vld <= 1'b1;
          r_rsp_ok  <= 1'b1;
          r_rsp_idx <= r_tcam_idx;
          r_state   <= ST_RESP;
        end
        ST_CLEAR: begin
          if (&r_cnt) begin
            r_tcam_we <= 1'b0;
            r_rsp_vld <= 1'b1;
            r_rsp_ok  <= 1'b1;
            r_rsp_idx <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_tcam_idx <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_rdy) begin
            r_rsp_vld <= 1'b0;
            r_rsp_ok  <= 1'b0;
            r_rsp_idx <= '0;
            r_req_rdy <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_rdy   = r_req_rdy;
  assign rsp_vld   = r_rsp_vld;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_idx   = r_rsp_idx;
  assign tcam_we   = r_tcam_we;
  assign tcam_idx  = r_tcam_idx;
  assign tcam_data = r_tcam_data;
  assign tcam_mask = r_tcam_mask;
  assign tcam_vld  = r_tcam_vld;
  assign occ_cnt   = r_occ;
  assign full      = (r_occ == CNT_W'(TCAM_DEPTH));
  assign empty     = (r_occ == '0);

endmodule

// File: tb/tb_tcam_rule_mgr.sv
// Bench for tcam_rule_mgr: directed scenarios plus random ops against an array-based rule-table model.
module tb_tcam_rule_mgr;
  import tcam_rule_mgr_pkg::*;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  tcam_op_t      req_op = TCAM_OP_INSERT;
  logic [3:0]    req_idx = '0;
  logic [W-1:0]  req_data = '0;
  logic [W-1:0]  req_mask = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b1;
  logic          rsp_ok;
  logic [3:0]    rsp_idx;
  logic          tcam_we;
  logic [3:0]    tcam_idx;
  logic [W-1:0]  tcam_data;
  logic [W-1:0]  tcam_mask;
  logic          tcam_vld;
  logic [4:0]    occ_cnt;
  logic          full;
  logic          empty;

  tcam_rule_mgr #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_idx(req_idx),
    .req_data(req_data), .req_mask(req_mask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_ok(rsp_ok), .rsp_idx(rsp_idx),
    .tcam_we(tcam_we), .tcam_idx(tcam_idx), .tcam_data(tcam_data),
    .tcam_mask(tcam_mask), .tcam_vld(tcam_vld),
    .occ_cnt(occ_cnt), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference table: one occupied flag per entry.
  bit mdl[D];

  logic       g_ok;
  logic [3:0] g_idx;
  int         g_lat;
  logic [4:0] g_occ;
  logic       g_full;
  logic       g_empty;
  int         g_rdy_bad;
  int         g_stall_bad;
  int         wl_cyc[$];
  logic [3:0] wl_idx[$];
  logic       wl_vld[$];
  logic [W-1:0] wl_data[$];
  logic [W-1:0] wl_mask[$];

  function automatic int mdl_lowest();
    for (int i = 0; i < D; i++) if (!mdl[i]) return i;
    return -1;
  endfunction

  function automatic int mdl_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mdl[i]);
    return n;
  endfunction

  // Issues one request, logs TCAM writes cycle by cycle, captures the response.
  task automatic run_op(input tcam_op_t op, input logic [3:0] idx, input logic [W-1:0] d,
                        input logic [W-1:0] m, input int stall);
    logic       s_ok;
    logic [3:0] s_idx;
    wl_cyc.delete(); wl_idx.delete(); wl_vld.delete(); wl_data.delete(); wl_mask.delete();
    g_lat = -1; g_rdy_bad = 0; g_stall_bad = 0;
    g_ok = 1'bx; g_idx = 'x; g_occ = 'x; g_full = 1'bx; g_empty = 1'bx;
    @(negedge clk);
    req_op = op; req_idx = idx; req_data = d; req_mask = m; req_vld = 1'b1;
    rsp_rdy = (stall == 0);
    tests++;
    if (req_rdy !== 1'b1) begin
      fails++; $display("FAIL req_rdy_idle: got %b want 1", req_rdy);
    end
    @(posedge clk);
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      req_vld = 1'b0;
      req_data = $urandom;
      if (tcam_we === 1'b1) begin
        wl_cyc.push_back(c); wl_idx.push_back(tcam_idx); wl_vld.push_back(tcam_vld);
        wl_data.push_back(tcam_data); wl_mask.push_back(tcam_mask);
      end
      if (req_rdy !== 1'b0) g_rdy_bad++;
      if (rsp_vld === 1'b1) begin
        g_lat = c; g_ok = rsp_ok; g_idx = rsp_idx;
        g_occ = occ_cnt; g_full = full; g_empty = empty;
        break;
      end
    end
    tests++;
    if (g_lat < 0) begin
      fails++; $display("FAIL rsp_timeout: no rsp_vld within 64 cycles (op %0d)", op);
    end
    if (stall > 0 && g_lat > 0) begin
      s_ok = rsp_ok; s_idx = rsp_idx;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (rsp_vld !== 1'b1 || rsp_ok !== s_ok || rsp_idx !== s_idx ||
            req_rdy !== 1'b0 || tcam_we !== 1'b0) g_stall_bad++;
      end
      rsp_rdy = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({req_rdy, rsp_vld, rsp_ok, rsp_idx} !== 7'b1_0_0_0000) begin
      fails++; $display("FAIL reset_rsp: got rdy/vld/ok/idx=%b want 1000000", {req_rdy, rsp_vld, rsp_ok, rsp_idx});
    end
    tests++;
    if ({tcam_we, tcam_idx, tcam_data, tcam_mask, tcam_vld} !== '0) begin
      fails++; $display("FAIL reset_tcam: got we=%b idx=%0d data=%h mask=%h vld=%b want all 0",
                        tcam_we, tcam_idx, tcam_data, tcam_mask, tcam_vld);
    end
    tests++;
    if (occ_cnt !== 5'd0 || full !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL reset_occ: got occ=%0d full=%b empty=%b want 0 0 1", occ_cnt, full, empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    foreach (mdl[i]) mdl[i] = 1'b0;
  endtask

  task automatic test_insert_first();
    run_op(TCAM_OP_INSERT, 4'd0, 32'hDEAD_BEEF, 32'hFFFF_0000, 0);
    mdl[0] = 1'b1;
    tests++;
    if (wl_cyc.size() != 1) begin
      fails++; $display("FAIL ins_first_wecount: got %0d writes want 1", wl_cyc.size());
    end else begin
      tests++;
      if (wl_cyc[0] != 1 || wl_idx[0] !== 4'd0 || wl_vld[0] !== 1'b1 ||
          wl_data[0] !== 32'hDEAD_BEEF || wl_mask[0] !== 32'hFFFF_0000) begin
        fails++; $display("FAIL ins_first_write: got cyc=%0d idx=%0d vld=%b data=%h mask=%h want 1 0 1 deadbeef ffff0000",
                          wl_cyc[0], wl_idx[0], wl_vld[0], wl_data[0], wl_mask[0]);
      end
    end
    tests++;
    if (g_lat != 2 || g_ok !== 1'b1 || g_idx !== 4'd0) begin
      fails++; $display("FAIL ins_first_rsp: got lat=%0d ok=%b idx=%0d want 2 1 0", g_lat, g_ok, g_idx);
    end
    tests++;
    if (g_occ !== 5'd1 || g_empty !== 1'b0 || g_full !== 1'b0) begin
      fails++; $display("FAIL ins_first_occ: got occ=%0d empty=%b full=%b want 1 0 0", g_occ, g_empty, g_full);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] d, m;
    int exp;
    while (mdl_count() < D) begin
      d = $urandom; m = $urandom;
      exp = mdl_lowest();
      run_op(TCAM_OP_INSERT, 4'($urandom_range(0, 15)), d, m, 0);
      mdl[exp] = 1'b1;
      tests++;
      if (g_ok !== 1'b1 || g_idx !== 4'(exp) || wl_idx.size() != 1 ||
          (wl_idx.size() == 1 && (wl_idx[0] !== 4'(exp) || wl_data[0] !== d || wl_mask[0] !== m))) begin
        fails++; $display("FAIL fill_insert: got ok=%b idx=%0d writes=%0d want ok=1 idx=%0d writes=1", g_ok, g_idx, wl_idx.size(), exp);
      end
    end
    tests++;
    if (g_full !== 1'b1 || g_occ !== 5'd16) begin
      fails++; $display("FAIL fill_full: got full=%b occ=%0d want 1 16", g_full, g_occ);
    end
  endtask

  task automatic test_overflow();
    run_op(TCAM_OP_INSERT, 4'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    tests++;
    if (g_ok !== 1'b0 || g_idx !== 4'd0 || g_lat != 1 || wl_cyc.size() != 0) begin
      fails++; $display("FAIL overflow: got ok=%b idx=%0d lat=%0d writes=%0d want 0 0 1 0", g_ok, g_idx, g_lat, wl_cyc.size());
    end
    tests++;
    if (g_full !== 1'b1) begin
      fails++; $display("FAIL overflow_full: got %b want 1", g_full);
    end
  endtask

  task automatic test_delete_reinsert();
    run_op(TCAM_OP_DELETE, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    mdl[5] = 1'b0;
    tests++;
    if (wl_cyc.size() != 1 || (wl_cyc.size() == 1 &&
        (wl_idx[0] !== 4'd5 || wl_vld[0] !== 1'b0 || wl_data[0] !== '0 || wl_mask[0] !== '0))) begin
      fails++; $display("FAIL del5_write: got writes=%0d want one write idx=5 vld=0 data=0 mask=0", wl_cyc.size());
    end
    tests++;
    if (g_ok !== 1'b1 || g_idx !== 4'd5 || g_lat != 2 || g_occ !== 5'd15 || g_full !== 1'b0) begin
      fails++; $display("FAIL del5_rsp: got ok=%b idx=%0d lat=%0d occ=%0d full=%b want 1 5 2 15 0",
                        g_ok, g_idx, g_lat, g_occ, g_full);
    end
    run_op(TCAM_OP_INSERT, 4'd0, 32'hCAFE_F00D, 32'h0000_FFFF, 0);
    mdl[5] = 1'b1;
    tests++;
    if (g_ok !== 1'b1 || g_idx !== 4'd5 || g_full !== 1'b1) begin
      fails++; $display("FAIL reinsert: got ok=%b idx=%0d full=%b want 1 5 1", g_ok, g_idx, g_full);
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    run_op(TCAM_OP_CLEAR, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    foreach (mdl[i]) mdl[i] = 1'b0;
    tests++;
    if (wl_cyc.size() != D) begin
      fails++; $display("FAIL clear_wecount: got %0d writes want %0d", wl_cyc.size(), D);
    end else begin
      for (int i = 0; i < D; i++)
        if (wl_cyc[i] != i + 1 || wl_idx[i] !== 4'(i) || wl_vld[i] !== 1'b0 ||
            wl_data[i] !== '0 || wl_mask[i] !== '0) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL clear_sweep: got %0d bad write cycles want 0", bad);
      end
    end
    tests++;
    if (g_lat != D + 1 || g_ok !== 1'b1 || g_idx !== 4'd0 || g_occ !== 5'd0 || g_empty !== 1'b1) begin
      fails++; $display("FAIL clear_rsp: got lat=%0d ok=%b idx=%0d occ=%0d empty=%b want 17 1 0 0 1",
                        g_lat, g_ok, g_idx, g_occ, g_empty);
    end
  endtask

  task automatic test_fail_ops();
    run_op(TCAM_OP_DELETE, 4'd9, 32'h0, 32'h0, 0);
    tests++;
    if (g_ok !== 1'b0 || g_idx !== 4'd0 || g_lat != 1 || wl_cyc.size() != 0) begin
      fails++; $display("FAIL del_empty: got ok=%b idx=%0d lat=%0d writes=%0d want 0 0 1 0", g_ok, g_idx, g_lat, wl_cyc.size());
    end
    run_op(TCAM_OP_RSVD, 4'd3, 32'hAAAA_5555, 32'hFFFF_FFFF, 0);
    tests++;
    if (g_ok !== 1'b0 || g_idx !== 4'd0 || g_lat != 1 || wl_cyc.size() != 0 || g_occ !== 5'd0) begin
      fails++; $display("FAIL rsvd_op: got ok=%b idx=%0d lat=%0d writes=%0d occ=%0d want 0 0 1 0 0",
                        g_ok, g_idx, g_lat, wl_cyc.size(), g_occ);
    end
  endtask

  task automatic test_stall();
    int exp = mdl_lowest();
    run_op(TCAM_OP_INSERT, 4'd0, 32'h0BAD_CAFE, 32'hFF00_FF00, 5);
    mdl[exp] = 1'b1;
    tests++;
    if (g_stall_bad != 0 || g_rdy_bad != 0) begin
      fails++; $display("FAIL stall_hold: got %0d unstable cycles, %0d req_rdy-high cycles want 0 0", g_stall_bad, g_rdy_bad);
    end
    tests++;
    if (g_ok !== 1'b1 || g_idx !== 4'(exp)) begin
      fails++; $display("FAIL stall_rsp: got ok=%b idx=%0d want 1 %0d", g_ok, g_idx, exp);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 99);
      tcam_op_t op;
      logic [3:0] ix = 4'($urandom_range(0, 15));
      bit exp_ok; int exp_idx, exp_lat, exp_we;
      op = (r < 55) ? TCAM_OP_INSERT : (r < 88) ? TCAM_OP_DELETE : (r < 93) ? TCAM_OP_CLEAR : TCAM_OP_RSVD;
      exp_ok = 1'b0; exp_idx = 0; exp_lat = 1; exp_we = 0;
      if (op == TCAM_OP_INSERT && mdl_count() < D) begin
        exp_ok = 1'b1; exp_idx = mdl_lowest(); exp_lat = 2; exp_we = 1;
      end else if (op == TCAM_OP_DELETE && mdl[ix]) begin
        exp_ok = 1'b1; exp_idx = int'(ix); exp_lat = 2; exp_we = 1;
      end else if (op == TCAM_OP_CLEAR) begin
        exp_ok = 1'b1; exp_lat = D + 1; exp_we = D;
      end
      run_op(op, ix, $urandom, $urandom, int'($urandom_range(0, 2)));
      if (op == TCAM_OP_INSERT && exp_ok) mdl[exp_idx] = 1'b1;
      if (op == TCAM_OP_DELETE && exp_ok) mdl[ix] = 1'b0;
      if (op == TCAM_OP_CLEAR) foreach (mdl[i]) mdl[i] = 1'b0;
      tests++;
      if (g_ok !== exp_ok || g_idx !== 4'(exp_idx) || g_lat != exp_lat || wl_cyc.size() != exp_we) begin
        fails++; $display("FAIL rand_rsp[%0d] op=%0d: got ok=%b idx=%0d lat=%0d we=%0d want %b %0d %0d %0d",
                          n, op, g_ok, g_idx, g_lat, wl_cyc.size(), exp_ok, exp_idx, exp_lat, exp_we);
      end
      tests++;
      if (g_occ !== 5'(mdl_count()) || g_full !== (mdl_count() == D) || g_empty !== (mdl_count() == 0) ||
          g_stall_bad != 0) begin
        fails++; $display("FAIL rand_occ[%0d]: got occ=%0d full=%b empty=%b unstable=%0d want occ=%0d",
                          n, g_occ, g_full, g_empty, g_stall_bad, mdl_count());
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    run_op(TCAM_OP_INSERT, 4'd0, 32'h1111_2222, 32'hFFFF_FFFF, 0);
    run_op(TCAM_OP_INSERT, 4'd0, 32'h3333_4444, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    req_op = TCAM_OP_CLEAR; req_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (tcam_we !== 1'b1 || tcam_idx !== 4'd4) begin
      fails++; $display("FAIL midclear_sweep: got we=%b idx=%0d want 1 4", tcam_we, tcam_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    foreach (mdl[i]) mdl[i] = 1'b0;
    tests++;
    if ({req_rdy, rsp_vld, rsp_ok, rsp_idx, tcam_we, tcam_idx, tcam_vld} !== 16'b1_0_0_0000_0_0000_0 ||
        tcam_data !== '0 || tcam_mask !== '0 || occ_cnt !== 5'd0 || full !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL async_reset: got rdy=%b rsp_vld=%b we=%b idx=%0d occ=%0d empty=%b want reset values",
                        req_rdy, rsp_vld, tcam_we, tcam_idx, occ_cnt, empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(TCAM_OP_INSERT, 4'd0, 32'h5555_6666, 32'hFFFF_FFFF, 0);
    mdl[0] = 1'b1;
    tests++;
    if (g_ok !== 1'b1 || g_idx !== 4'd0 || g_occ !== 5'd1) begin
      fails++; $display("FAIL post_reset_insert: got ok=%b idx=%0d occ=%0d want 1 0 1", g_ok, g_idx, g_occ);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_insert_first();
    test_fill();
    test_overflow();
    test_delete_reinsert();
    test_clear();
    test_fail_ops();
    test_stall();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
